// File: rtl/hps_reset_sequencer_pkg.sv
// Shared types and defaults for the HPS reset request scheduler.
// Request-type encoding matches the active_type port values seen by software.
package hps_reset_pkg;

   typedef enum logic [1:0] {
      RT_NONE  = 2'd0,
      RT_COLD  = 2'd1,
      RT_WARM  = 2'd2,
      RT_DEBUG = 2'd3
   } reset_type_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } seq_state_t;

   localparam int DEF_COLD_PULSE  = 6;
   localparam int DEF_WARM_PULSE  = 2;
   localparam int DEF_DEBUG_PULSE = 32;
   localparam int DEF_HOLDOFF     = 16;

   localparam logic [7:0] DROP_MAX = 8'hFF;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Fixed priority: cold > warm > debug.
   function automatic reset_type_t pick_type(input logic c, input logic w, input logic d);
      if (c) return RT_COLD;
      if (w) return RT_WARM;
      if (d) return RT_DEBUG;
      return RT_NONE;
   endfunction

endpackage

// File: rtl/hps_reset_sequencer_if.sv
// Request/response bundle between fabric reset-request logic and the sequencer.
// master = request source side, slave = sequencer side.
interface hps_reset_sequencer_if;
   import hps_reset_pkg::*;

   logic        req_cold;
   logic        req_warm;
   logic        req_debug;
   logic        hps_cold_reset;
   logic        hps_warm_reset;
   logic        hps_debug_reset;
   logic        busy;
   reset_type_t active_type;
   logic [7:0]  drop_count;

   modport master (
      output req_cold, req_warm, req_debug,
      input  hps_cold_reset, hps_warm_reset, hps_debug_reset,
      input  busy, active_type, drop_count
   );

   modport slave (
      input  req_cold, req_warm, req_debug,
      output hps_cold_reset, hps_warm_reset, hps_debug_reset,
      output busy, active_type, drop_count
   );

endinterface

// File: rtl/hps_reset_sequencer_req_edge.sv
// One request line: rising-edge detector plus its pending latch.
// prev resets high so a line held high through reset never reads as a new request.
module hps_req_edge (
   input  logic fpga_clk_50,
   input  logic fpga_reset,
   input  logic req,
   input  logic set,
   input  logic clr,
   output logic rise,
   output logic pend
);

   logic prev;

   assign rise = req & ~prev;

   always_ff @(posedge fpga_clk_50) begin
      if (fpga_reset) begin
         prev <= 1'b1;
         pend <= 1'b0;
      end else begin
         prev <= req;
         if (clr)
            pend <= 1'b0;
         else if (set)
            pend <= 1'b1;
      end
   end

endmodule

// File: rtl/hps_reset_sequencer.sv
// Schedules cold/warm/debug HPS reset requests one at a time with fixed
// priority, per-type pulse width and a guard interval after every pulse.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | nothing in flight, all outputs low, waiting for a request
//   ST_ASSERT  | one reset output high (type_q), counting down the pulse width
//   ST_HOLDOFF | all outputs low, counting down the guard before the next grant
module hps_reset_sequencer
   import hps_reset_pkg::*;
#(
   parameter int COLD_PULSE  = DEF_COLD_PULSE,
   parameter int WARM_PULSE  = DEF_WARM_PULSE,
   parameter int DEBUG_PULSE = DEF_DEBUG_PULSE,
   parameter int HOLDOFF     = DEF_HOLDOFF
) (
   input  logic                  fpga_clk_50,
   input  logic                  fpga_reset,
   hps_reset_sequencer_if.slave  bus
);

   localparam int CW = $clog2(max4(COLD_PULSE, WARM_PULSE, DEBUG_PULSE, HOLDOFF)) + 1;

   localparam logic [CW-1:0] COLD_LOAD  = CW'(COLD_PULSE - 1);
   localparam logic [CW-1:0] WARM_LOAD  = CW'(WARM_PULSE - 1);
   localparam logic [CW-1:0] DEBUG_LOAD = CW'(DEBUG_PULSE - 1);
   localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLDOFF - 1);

   seq_state_t    state_q, state_d;
   reset_type_t   type_q, type_d;
   reset_type_t   grant;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    drop_q, drop_d;
   logic [8:0]    drop_sum;
   logic [1:0]    drop_n;

   logic rise_c, rise_w, rise_d;
   logic pend_c, pend_w, pend_d;
   logic want_c, want_w, want_d;
   logic set_c, set_w, set_d;
   logic clr_c, clr_w, clr_d;
   logic same_c, same_w, same_d;
   logic cold_grant, in_assert;

   hps_req_edge u_edge_cold (
      .fpga_clk_50 (fpga_clk_50),
      .fpga_reset  (fpga_reset),
      .req         (bus.req_cold),
      .set         (set_c),
      .clr         (clr_c),
      .rise        (rise_c),
      .pend        (pend_c)
   );

   hps_req_edge u_edge_warm (
      .fpga_clk_50 (fpga_clk_50),
      .fpga_reset  (fpga_reset),
      .req         (bus.req_warm),
      .set         (set_w),
      .clr         (clr_w),
      .rise        (rise_w),
      .pend        (pend_w)
   );

   hps_req_edge u_edge_debug (
      .fpga_clk_50 (fpga_clk_50),
      .fpga_reset  (fpga_reset),
      .req         (bus.req_debug),
      .set         (set_d),
      .clr         (clr_d),
      .rise        (rise_d),
      .pend        (pend_d)
   );

   // A request is eligible this cycle whether it just arrived or was latched earlier.
   assign want_c = rise_c | pend_c;
   assign want_w = rise_w | pend_w;
   assign want_d = rise_d | pend_d;

   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      cnt_d   = cnt_q;
      grant   = RT_NONE;
      case (state_q)
         ST_IDLE: begin
            grant = pick_type(want_c, want_w, want_d);
         end
         ST_ASSERT: begin
            cnt_d = cnt_q - CW'(1);
            if (rise_c && type_q != RT_COLD) begin
               grant = RT_COLD;
            end else if (cnt_q == '0) begin
               state_d = ST_HOLDOFF;
               cnt_d   = HOLD_LOAD;
            end
         end
         ST_HOLDOFF: begin
            cnt_d = cnt_q - CW'(1);
            if (rise_c && type_q != RT_COLD) begin
               grant = RT_COLD;
            end else if (cnt_q == '0) begin
               grant = pick_type(want_c, want_w, want_d);
               if (grant == RT_NONE) begin
                  state_d = ST_IDLE;
                  type_d  = RT_NONE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            type_d  = RT_NONE;
         end
      endcase

      if (grant != RT_NONE) begin
         state_d = ST_ASSERT;
         type_d  = grant;
         case (grant)
            RT_COLD: cnt_d = COLD_LOAD;
            RT_WARM: cnt_d = WARM_LOAD;
            default: cnt_d = DEBUG_LOAD;
         endcase
      end
   end

   // A cold grant discards whatever warm/debug work is waiting or arriving.
   assign cold_grant = (grant == RT_COLD);
   assign in_assert  = (state_q == ST_ASSERT) && !cold_grant;

   assign same_c = in_assert && (type_q == RT_COLD)  && rise_c;
   assign same_w = in_assert && (type_q == RT_WARM)  && rise_w;
   assign same_d = in_assert && (type_q == RT_DEBUG) && rise_d;

   assign clr_c = cold_grant;
   assign clr_w = (grant == RT_WARM)  || cold_grant;
   assign clr_d = (grant == RT_DEBUG) || cold_grant;

   assign set_c = rise_c & ~clr_c & ~same_c;
   assign set_w = rise_w & ~clr_w & ~same_w;
   assign set_d = rise_d & ~clr_d & ~same_d;

   assign drop_n = 2'(cold_grant & want_w) + 2'(cold_grant & want_d)
                 + 2'(same_c | same_w | same_d);

   assign drop_sum = {1'b0, drop_q} + 9'(drop_n);
   assign drop_d   = drop_sum[8] ? DROP_MAX : drop_sum[7:0];

   always_ff @(posedge fpga_clk_50) begin
      if (fpga_reset) begin
         state_q <= ST_IDLE;
         type_q  <= RT_NONE;
         cnt_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end

   // Outputs are registered from the next state so the HPS reset pins never glitch.
   always_ff @(posedge fpga_clk_50) begin
      if (fpga_reset) begin
         bus.hps_cold_reset  <= 1'b0;
         bus.hps_warm_reset  <= 1'b0;
         bus.hps_debug_reset <= 1'b0;
         bus.busy            <= 1'b0;
         bus.active_type     <= RT_NONE;
      end else begin
         bus.hps_cold_reset  <= (state_d == ST_ASSERT) && (type_d == RT_COLD);
         bus.hps_warm_reset  <= (state_d == ST_ASSERT) && (type_d == RT_WARM);
         bus.hps_debug_reset <= (state_d == ST_ASSERT) && (type_d == RT_DEBUG);
         bus.busy            <= (state_d != ST_IDLE);
         bus.active_type     <= (state_d == ST_ASSERT) ? type_d : RT_NONE;
      end
   end

   assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Directed bench for hps_reset_sequencer: drives request edges at negedge and
// measures pulse start/width and busy time over fixed windows.
module tb_hps_reset_sequencer;

   logic fpga_clk_50 = 1'b0;
   logic fpga_reset  = 1'b1;

   int n_total = 0;
   int n_bad   = 0;

   int n_c, n_w, n_d, n_busy;
   int f_c, f_w, f_d;
   logic [1:0] at0;

   hps_reset_sequencer_if bus ();

   hps_reset_sequencer dut (
      .fpga_clk_50 (fpga_clk_50),
      .fpga_reset  (fpga_reset),
      .bus         (bus)
   );

   always #10 fpga_clk_50 = ~fpga_clk_50;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Sample index 0 is the negedge right after the edge that samples the stimulus.
   task automatic watch(input int n);
      n_c = 0; n_w = 0; n_d = 0; n_busy = 0;
      f_c = -1; f_w = -1; f_d = -1;
      at0 = 2'd0;
      for (int i = 0; i < n; i++) begin
         @(negedge fpga_clk_50);
         if (i == 0) at0 = bus.active_type;
         if (bus.hps_cold_reset)  begin n_c++; if (f_c < 0) f_c = i; end
         if (bus.hps_warm_reset)  begin n_w++; if (f_w < 0) f_w = i; end
         if (bus.hps_debug_reset) begin n_d++; if (f_d < 0) f_d = i; end
         if (bus.busy) n_busy++;
      end
   endtask

   task automatic do_reset();
      bus.req_cold  = 1'b0;
      bus.req_warm  = 1'b0;
      bus.req_debug = 1'b0;
      fpga_reset    = 1'b1;
      repeat (2) @(negedge fpga_clk_50);
      fpga_reset = 1'b0;
      @(negedge fpga_clk_50);
   endtask

   initial begin
      bus.req_cold  = 1'b0;
      bus.req_warm  = 1'b0;
      bus.req_debug = 1'b0;
      repeat (3) @(negedge fpga_clk_50);

      chk("rst_cold",  32'(bus.hps_cold_reset),  0);
      chk("rst_warm",  32'(bus.hps_warm_reset),  0);
      chk("rst_debug", 32'(bus.hps_debug_reset), 0);
      chk("rst_busy",  32'(bus.busy),            0);
      chk("rst_type",  32'(bus.active_type),     0);
      chk("rst_drop",  32'(bus.drop_count),      0);
      fpga_reset = 1'b0;
      @(negedge fpga_clk_50);

      // single warm request
      bus.req_warm = 1'b1;
      watch(40);
      chk("warm_start", 32'(f_w),    0);
      chk("warm_width", 32'(n_w),    2);
      chk("warm_busy",  32'(n_busy), 18);
      chk("warm_type",  32'(at0),    2);
      chk("warm_cold",  32'(n_c),    0);
      chk("warm_drop",  32'(bus.drop_count), 0);

      // cold, warm and debug in the same cycle
      do_reset();
      bus.req_cold = 1'b1; bus.req_warm = 1'b1; bus.req_debug = 1'b1;
      watch(60);
      chk("all_cstart", 32'(f_c),    0);
      chk("all_cwidth", 32'(n_c),    6);
      chk("all_warm",   32'(n_w),    0);
      chk("all_debug",  32'(n_d),    0);
      chk("all_busy",   32'(n_busy), 22);
      chk("all_type",   32'(at0),    1);
      chk("all_drop",   32'(bus.drop_count), 2);

      // warm and debug together: warm served, debug after the guard
      do_reset();
      bus.req_warm = 1'b1; bus.req_debug = 1'b1;
      watch(90);
      chk("wd_wstart", 32'(f_w),    0);
      chk("wd_wwidth", 32'(n_w),    2);
      chk("wd_dstart", 32'(f_d),    18);
      chk("wd_dwidth", 32'(n_d),    32);
      chk("wd_busy",   32'(n_busy), 66);
      chk("wd_drop",   32'(bus.drop_count), 0);

      // debug preempted by cold 10 clocks in
      do_reset();
      bus.req_debug = 1'b1;
      watch(10);
      chk("pre_dstart", 32'(f_d), 0);
      chk("pre_dwidth", 32'(n_d), 10);
      chk("pre_dtype",  32'(at0), 3);
      bus.req_cold = 1'b1;
      watch(40);
      chk("pre_cstart", 32'(f_c),    0);
      chk("pre_cwidth", 32'(n_c),    6);
      chk("pre_dafter", 32'(n_d),    0);
      chk("pre_ctype",  32'(at0),    1);
      chk("pre_busy",   32'(n_busy), 22);
      chk("pre_drop",   32'(bus.drop_count), 0);

      // cold held high through reset release
      bus.req_cold = 1'b1; bus.req_warm = 1'b0; bus.req_debug = 1'b0;
      fpga_reset   = 1'b1;
      repeat (2) @(negedge fpga_clk_50);
      fpga_reset = 1'b0;
      watch(30);
      chk("hold_cold", 32'(n_c),    0);
      chk("hold_busy", 32'(n_busy), 0);

      // reset during the third cycle of a debug pulse
      do_reset();
      bus.req_debug = 1'b1;
      watch(3);
      chk("mid_dwidth", 32'(n_d), 3);
      fpga_reset = 1'b1;
      @(negedge fpga_clk_50);
      chk("mid_debug", 32'(bus.hps_debug_reset), 0);
      chk("mid_busy",  32'(bus.busy),            0);
      chk("mid_type",  32'(bus.active_type),     0);
      fpga_reset = 1'b0;
      watch(60);
      chk("mid_replay", 32'(n_d),    0);
      chk("mid_idle",   32'(n_busy), 0);

      // same-type rises during debug pulses: 15 drops per pulse, saturating at 255
      do_reset();
      for (int p = 0; p < 20; p++) begin
         bus.req_debug = 1'b1;
         @(negedge fpga_clk_50);
         for (int t = 0; t < 15; t++) begin
            bus.req_debug = 1'b0;
            @(negedge fpga_clk_50);
            bus.req_debug = 1'b1;
            @(negedge fpga_clk_50);
         end
         bus.req_debug = 1'b0;
         repeat (60) @(negedge fpga_clk_50);
         if (p == 0)  chk("drop_p1",  32'(bus.drop_count), 15);
         if (p == 15) chk("drop_p16", 32'(bus.drop_count), 240);
         if (p == 16) chk("drop_p17", 32'(bus.drop_count), 255);
         if (p == 19) chk("drop_sat", 32'(bus.drop_count), 255);
      end
      chk("drop_idle", 32'(bus.busy), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
